// File: rtl/multi_pwm_controller.sv
// Multi-channel PWM generator: runtime prescaler, edge/centre-aligned counter, double-buffered duties.
// Optional PWM_PHASE_STAGGER_EN offsets each channel's edge-mode compare to spread switching edges.
module multi_pwm_controller #(
   parameter int NUM_CH     = 16,
   parameter int RES        = 8,
   parameter int PRESCALE_W = 11
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [PRESCALE_W-1:0]     prescale_div,
   input  logic                      center_mode,
   input  logic [NUM_CH-1:0]         en_out,
   input  logic [NUM_CH-1:0]         en_pwm,
   input  logic                      duty_wr_en,
   input  logic [$clog2(NUM_CH)-1:0] duty_wr_ch,
   input  logic [RES-1:0]            duty_wr_data,
   output logic [NUM_CH-1:0]         out,
   output logic                      period_tick,
   output logic                      pending
);

   localparam logic [RES-1:0] CNT_MAX = '1;

   logic [PRESCALE_W-1:0] pcnt;
   logic [RES-1:0]        cnt;
   logic                  dir_down;
   logic                  mode_center;
   logic                  primed;
   logic [RES-1:0]        shadow [NUM_CH];
   logic [RES-1:0]        active [NUM_CH];
   logic                  tick;
   logic                  boundary;
   logic                  wr_ok;
   logic [NUM_CH-1:0]     cmp;

   // >= lets a divisor lowered mid-count wrap on the very next clock
   assign tick  = (pcnt >= prescale_div);
   assign wr_ok = duty_wr_en && (int'(duty_wr_ch) < NUM_CH);

   // The first tick after reset always opens a period, whatever cnt holds.
   always_comb begin
      boundary = 1'b0;
      if (tick) begin
         if (!primed)
            boundary = 1'b1;
         else if (!mode_center)
            boundary = (cnt == CNT_MAX);
         else
            boundary = dir_down && (cnt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pcnt        <= '0;
         cnt         <= '0;
         dir_down    <= 1'b0;
         mode_center <= 1'b0;
         primed      <= 1'b0;
         period_tick <= 1'b0;
      end else begin
         pcnt        <= tick ? '0 : pcnt + 1'b1;
         period_tick <= boundary;
         if (boundary) begin
            cnt         <= '0;
            dir_down    <= 1'b0;
            mode_center <= center_mode;
            primed      <= 1'b1;
         end else if (tick) begin
            if (!mode_center) begin
               cnt <= cnt + 1'b1;
            end else if (!dir_down) begin
               // top endpoint is held one extra tick before turning down
               if (cnt == CNT_MAX)
                  dir_down <= 1'b1;
               else
                  cnt <= cnt + 1'b1;
            end else begin
               cnt <= cnt - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         if (boundary) begin
            for (int i = 0; i < NUM_CH; i++)
               active[i] <= shadow[i];
         end
         if (wr_ok)
            shadow[duty_wr_ch] <= duty_wr_data;
         // a write landing on a boundary keeps pending set for the next period
         if (wr_ok)
            pending <= 1'b1;
         else if (boundary)
            pending <= 1'b0;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [RES-1:0] ref_cnt;
`ifdef PWM_PHASE_STAGGER_EN
      localparam logic [RES-1:0] OFFSET = RES'(g * ((1 << RES) / NUM_CH));
      assign ref_cnt = mode_center ? cnt : cnt + OFFSET;
`else
      assign ref_cnt = cnt;
`endif
      assign cmp[g] = (active[g] == CNT_MAX) || (ref_cnt < active[g]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         out <= '0;
      else
         out <= en_out & (~en_pwm | cmp);
   end

endmodule

// File: tb/tb_multi_pwm_controller.sv
// Directed bench for multi_pwm_controller: per-period duty vectors plus hand sequences for
// shadow timing, prescaler retargeting, out-of-range writes and mid-period reset.
module tb_multi_pwm_controller;

   localparam int NUM_CH     = 12;
   localparam int RES        = 8;
   localparam int PRESCALE_W = 11;
   localparam int CH_W       = $clog2(NUM_CH);

   logic                  clk;
   logic                  rst_n;
   logic [PRESCALE_W-1:0] prescale_div;
   logic                  center_mode;
   logic [NUM_CH-1:0]     en_out;
   logic [NUM_CH-1:0]     en_pwm;
   logic                  duty_wr_en;
   logic [CH_W-1:0]       duty_wr_ch;
   logic [RES-1:0]        duty_wr_data;
   logic [NUM_CH-1:0]     pwm_out;
   logic                  period_tick;
   logic                  pending;

   int n_pass  = 0;
   int n_total = 0;

   multi_pwm_controller #(
      .NUM_CH(NUM_CH), .RES(RES), .PRESCALE_W(PRESCALE_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .prescale_div(prescale_div), .center_mode(center_mode),
      .en_out(en_out), .en_pwm(en_pwm), .duty_wr_en(duty_wr_en), .duty_wr_ch(duty_wr_ch),
      .duty_wr_data(duty_wr_data), .out(pwm_out), .period_tick(period_tick), .pending(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int ch;
      int duty;
      bit wr;
      bit eo;
      bit ep;
      int div;
      bit ctr;
      int exp_wait;
      int exp_n;
      int exp_high;
      bit exp_first;
      bit exp_last;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic do_write(input int ch, input int data, input bit en);
      duty_wr_ch   = CH_W'(ch);
      duty_wr_data = RES'(data);
      duty_wr_en   = en;
      @(posedge clk);
      #1 duty_wr_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_tick(output int cycles);
      cycles = 0;
      do begin
         @(posedge clk);
         @(negedge clk);
         cycles++;
      end while (!period_tick && cycles < 5000);
   endtask

   task automatic measure(input int ch, input int n, output int highs, output bit first,
                          output bit last, output int tick_err);
      highs    = 0;
      tick_err = 0;
      first    = 1'b0;
      last     = 1'b0;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (pwm_out[ch]) highs++;
         if (k == 1) first = pwm_out[ch];
         if (k == n) last = pwm_out[ch];
         if (period_tick != (k == n)) tick_err++;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   cyc;
      int   highs;
      int   terr;
      bit   first;
      bit   last;
      vec_t v;

      //          ch duty   wr    eo    ep  div   ctr   wait   n   high first last
      vecs[0] = '{0,  64, 1'b1, 1'b1, 1'b1,  0, 1'b0,  255, 256,   64, 1'b1, 1'b0};
      vecs[1] = '{3,   0, 1'b1, 1'b1, 1'b1,  0, 1'b0,  255, 256,    0, 1'b0, 1'b0};
      vecs[2] = '{3, 255, 1'b1, 1'b1, 1'b1,  0, 1'b0,  255, 256,  256, 1'b1, 1'b1};
      vecs[3] = '{3, 254, 1'b1, 1'b1, 1'b1,  0, 1'b0,  255, 256,  254, 1'b1, 1'b0};
      vecs[4] = '{3, 254, 1'b0, 1'b1, 1'b0,  0, 1'b0,  255, 256,  256, 1'b1, 1'b1};
      vecs[5] = '{3, 254, 1'b0, 1'b0, 1'b1,  0, 1'b0,  255, 256,    0, 1'b0, 1'b0};
      vecs[6] = '{1, 128, 1'b1, 1'b1, 1'b1, 12, 1'b0, 3327, 3328, 1664, 1'b1, 1'b0};
      vecs[7] = '{2,  64, 1'b1, 1'b1, 1'b1,  0, 1'b1,  255, 512,  128, 1'b1, 1'b1};
      vecs[8] = '{2,  64, 1'b0, 1'b1, 1'b1,  0, 1'b0,  511, 256,   64, 1'b1, 1'b0};

      rst_n        = 1'b0;
      prescale_div = '0;
      center_mode  = 1'b0;
      en_out       = '0;
      en_pwm       = '0;
      duty_wr_en   = 1'b0;
      duty_wr_ch   = '0;
      duty_wr_data = '0;
      idle(3);
      check("reset out", int'(pwm_out), 0);
      check("reset period_tick", int'(period_tick), 0);
      check("reset pending", int'(pending), 0);

      rst_n  = 1'b1;
      en_out = '1;
      en_pwm = '1;
      idle(1);
      check("first tick after release", int'(period_tick), 1);
      check("first tick out", int'(pwm_out), 0);

      for (int r = 0; r < 9; r++) begin
         v = vecs[r];
         en_out        = '1;
         en_pwm        = '1;
         en_out[v.ch]  = v.eo;
         en_pwm[v.ch]  = v.ep;
         prescale_div  = PRESCALE_W'(v.div);
         center_mode   = v.ctr;
         do_write(v.ch, v.duty, v.wr);
         wait_tick(cyc);
         check($sformatf("row%0d boundary wait", r), cyc, v.exp_wait);
         measure(v.ch, v.exp_n, highs, first, last, terr);
         check($sformatf("row%0d high clocks", r), highs, v.exp_high);
         check($sformatf("row%0d first sample", r), int'(first), int'(v.exp_first));
         check($sformatf("row%0d last sample", r), int'(last), int'(v.exp_last));
         check($sformatf("row%0d period_tick placement", r), terr, 0);
      end

      // mid-period shadow write on ch5: old duty holds until the boundary
      do_write(5, 50, 1'b1);
      wait_tick(cyc);
      check("ch5 initial boundary wait", cyc, 255);
      idle(99);
      do_write(5, 200, 1'b1);
      check("ch5 pending after write", int'(pending), 1);
      check("ch5 old duty still active", int'(pwm_out[5]), 0);
      wait_tick(cyc);
      check("ch5 boundary wait", cyc, 156);
      check("ch5 pending cleared", int'(pending), 0);
      measure(5, 256, highs, first, last, terr);
      check("ch5 new duty high clocks", highs, 200);

      // write coincident with a boundary is deferred one period
      idle(255);
      do_write(5, 10, 1'b1);
      check("coincident period_tick", int'(period_tick), 1);
      check("coincident pending held", int'(pending), 1);
      measure(5, 256, highs, first, last, terr);
      check("coincident old duty kept", highs, 200);
      check("coincident pending cleared later", int'(pending), 0);
      measure(5, 256, highs, first, last, terr);
      check("coincident duty applied", highs, 10);

      // out-of-range channel write is ignored
      do_write(13, 99, 1'b1);
      check("bad channel pending", int'(pending), 0);
      wait_tick(cyc);
      check("bad channel boundary wait", cyc, 255);
      measure(5, 256, highs, first, last, terr);
      check("bad channel ch5 unchanged", highs, 10);

      // lower the divisor while pcnt=8: tick on the next clock, then every 4
      prescale_div = PRESCALE_W'(12);
      do_write(0, 1, 1'b1);
      wait_tick(cyc);
      check("div12 boundary wait", cyc, 3327);
      idle(8);
      prescale_div = PRESCALE_W'(3);
      idle(1);
      check("div retarget cnt0 out", int'(pwm_out[0]), 1);
      idle(1);
      check("div retarget immediate tick", int'(pwm_out[0]), 0);
      wait_tick(cyc);
      check("div3 boundary wait", cyc, 1019);

      // one-clock reset mid-period clears everything
      prescale_div = '0;
      idle(20);
      do_write(0, 64, 1'b1);
      check("pre-reset pending", int'(pending), 1);
      rst_n = 1'b0;
      idle(1);
      check("mid reset out", int'(pwm_out), 0);
      check("mid reset pending", int'(pending), 0);
      check("mid reset period_tick", int'(period_tick), 0);
      rst_n = 1'b1;
      idle(1);
      check("post reset first tick", int'(period_tick), 1);
      idle(3);
      check("post reset duties zero", int'(pwm_out), 0);
      check("post reset pending", int'(pending), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
